demuxcase: RTL

- Registered 1-to-8 stream demultiplexer; the inverse of the one-hot case mux.
- Routes one DW-bit input word to exactly one of 8 output lanes, chosen by a one-hot select.
- Each output lane has a single-entry holding register with valid/ready handshake.
- Sits between a shared producer and 8 independent consumers in the basic benchmark set.

---
 rtl/demuxcase.sv | 77 +++++++
 1 files changed

// File: rtl/demuxcase.sv
// Registered 1-to-8 stream demultiplexer: one-hot sel routes each input word into a per-lane holding register.
// Optional macro DEMUXCASE_DROPCNT_EN builds the saturating drop counter; otherwise drop_count is tied to zero.
module demuxcase #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      sel,
    input  logic [DW-1:0]   in,
    output logic [7:0]      out_valid,
    input  logic [7:0]      out_ready,
    output logic [8*DW-1:0] out,
    output logic [7:0]      drop_count
);
    localparam int LANES = 8;

    logic [LANES-1:0]    vld_p1;
    logic [LANES*DW-1:0] data_p1;
    logic [LANES-1:0]    can_accept;
    logic [LANES-1:0]    load;
    logic                legal;
    logic                accept;

    function automatic logic is_onehot(input logic [LANES-1:0] s);
        return (s != '0) && ((s & (s - {{(LANES-1){1'b0}}, 1'b1})) == '0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // A lane takes a word when empty or when its current word drains this cycle.
    assign legal      = is_onehot(sel);
    assign can_accept = ~vld_p1 | out_ready;
    assign in_ready   = legal ? |(can_accept & sel) : 1'b1;
    assign accept     = in_valid & in_ready & legal;
    assign load       = accept ? sel : '0;

    // Stage p1: per-lane holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= '0;
            data_p1 <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (load[i]) begin
                    data_p1[DW*i +: DW] <= in;
                    vld_p1[i]           <= 1'b1;
                end else if (out_ready[i]) begin
                    vld_p1[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out       = data_p1;

`ifdef DEMUXCASE_DROPCNT_EN
    logic [7:0] drop_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_p1 <= '0;
        end else if (in_valid && !legal) begin
            drop_p1 <= sat_inc(drop_p1);
        end
    end

    assign drop_count = drop_p1;
`else
    assign drop_count = 8'h00;
`endif

endmodule
